// File: rtl/sequencer_avl_cmd_master_if.sv
// Command/response and Avalon-MM bus bundle for sequencer_avl_cmd_master.
// The master modport is the command master's view: it takes commands, returns
// responses and drives the Avalon strobes. The slave modport is the mirror
// view used by whatever sits on the other side (sequencer and PHY manager).
interface sequencer_avl_cmd_master_if #(
    parameter int AVL_DATA_WIDTH = 32,
    parameter int AVL_ADDR_WIDTH = 16
);
    // Command side
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [AVL_ADDR_WIDTH-1:0] cmd_address;
    logic [AVL_DATA_WIDTH-1:0] cmd_writedata;

    // Response side
    logic                      resp_valid;
    logic [AVL_DATA_WIDTH-1:0] resp_readdata;
    logic                      resp_error;

    // Avalon-MM side
    logic [AVL_ADDR_WIDTH-1:0] avl_address;
    logic                      avl_write;
    logic [AVL_DATA_WIDTH-1:0] avl_writedata;
    logic                      avl_read;
    logic [AVL_DATA_WIDTH-1:0] avl_readdata;
    logic                      avl_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  avl_readdata, avl_waitrequest,
        output cmd_ready, resp_valid, resp_readdata, resp_error,
        output avl_address, avl_write, avl_writedata, avl_read
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output avl_readdata, avl_waitrequest,
        input  cmd_ready, resp_valid, resp_readdata, resp_error,
        input  avl_address, avl_write, avl_writedata, avl_read
    );
endinterface

// File: rtl/sequencer_avl_cmd_master.sv
// sequencer_avl_cmd_master
// Avalon-MM master issuing single reads/writes on behalf of the calibration
// sequencer. A valid/ready command becomes one Avalon strobe that is held
// through waitrequest, followed by a forced strobe-low gap of GAP_CYCLES
// cycles. Completion is reported with a one-cycle resp_valid pulse.
//
// Optional build macro: SEQ_AVL_CMD_MASTER_TIMEOUT_EN
//   When defined, a saturating wait counter aborts an access whose
//   waitrequest stays high for TIMEOUT_CYCLES cycles and reports resp_error.
//   When undefined, no counter is built, REQ waits forever, resp_error = 0.
module sequencer_avl_cmd_master #(
    parameter int AVL_DATA_WIDTH = 32,
    parameter int AVL_ADDR_WIDTH = 16,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_WIDTH  = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic                        avl_clk,
    input logic                        avl_reset,
    sequencer_avl_cmd_master_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Last value of the gap counter before returning to IDLE.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    // Out-of-range configurations show up as this marker scope in the
    // elaborated hierarchy; it carries no logic.
    if (GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT_CYCLES >= (2 ** TIMEOUT_WIDTH)) begin : g_illegal_config
    end

    logic [1:0]                state_reg;
    logic [3:0]                gap_cnt_reg;
    logic [AVL_ADDR_WIDTH-1:0] avl_address_reg;
    logic [AVL_DATA_WIDTH-1:0] avl_writedata_reg;
    logic                      avl_read_reg;
    logic                      avl_write_reg;
    logic                      resp_valid_reg;
    logic [AVL_DATA_WIDTH-1:0] resp_readdata_reg;
    logic                      timeout_hit;

    // Only cmd_ready is combinational: it reflects IDLE and is masked by reset.
    assign bus.cmd_ready     = (state_reg == IDLE) && !avl_reset;
    assign bus.avl_address   = avl_address_reg;
    assign bus.avl_writedata = avl_writedata_reg;
    assign bus.avl_read      = avl_read_reg;
    assign bus.avl_write     = avl_write_reg;
    assign bus.resp_valid    = resp_valid_reg;
    assign bus.resp_readdata = resp_readdata_reg;

`ifdef SEQ_AVL_CMD_MASTER_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX   = '1;
    localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] wait_cnt_reg;
    logic [TIMEOUT_WIDTH-1:0] wait_cnt_next;
    logic                     resp_error_reg;

    // Saturating increment; abort when this stalled cycle brings the count
    // up to the limit, so the strobe is high for exactly TIMEOUT_CYCLES.
    always_comb begin
        wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
        timeout_hit   = bus.avl_waitrequest && (wait_cnt_next >= WAIT_LIMIT);
    end

    // Wait counter: cleared when a command enters REQ, counts stalled REQ cycles.
    always_ff @(posedge avl_clk) begin
        if (avl_reset) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == IDLE && bus.cmd_valid) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == REQ && bus.avl_waitrequest) begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Error flag follows each REQ exit; normal completion takes priority.
    always_ff @(posedge avl_clk) begin
        if (avl_reset) begin
            resp_error_reg <= 1'b0;
        end else if (state_reg == REQ) begin
            if (!bus.avl_waitrequest) begin
                resp_error_reg <= 1'b0;
            end else if (timeout_hit) begin
                resp_error_reg <= 1'b1;
            end
        end
    end

    assign bus.resp_error = resp_error_reg;
`else
    assign timeout_hit    = 1'b0;
    assign bus.resp_error = 1'b0;
`endif

    // Main sequencing: command latch, strobe hold, completion capture, gap.
    always_ff @(posedge avl_clk) begin
        if (avl_reset) begin
            state_reg         <= IDLE;
            gap_cnt_reg       <= '0;
            avl_address_reg   <= '0;
            avl_writedata_reg <= '0;
            avl_read_reg      <= 1'b0;
            avl_write_reg     <= 1'b0;
            resp_valid_reg    <= 1'b0;
            resp_readdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        avl_address_reg   <= bus.cmd_address;
                        avl_writedata_reg <= bus.cmd_writedata;
                        avl_write_reg     <= bus.cmd_write;
                        avl_read_reg      <= !bus.cmd_write;
                        state_reg         <= REQ;
                    end
                end
                REQ: begin
                    if (!bus.avl_waitrequest) begin
                        avl_read_reg      <= 1'b0;
                        avl_write_reg     <= 1'b0;
                        resp_valid_reg    <= 1'b1;
                        resp_readdata_reg <= avl_read_reg ? bus.avl_readdata : '0;
                        gap_cnt_reg       <= '0;
                        state_reg         <= GAP;
                    end else if (timeout_hit) begin
                        avl_read_reg      <= 1'b0;
                        avl_write_reg     <= 1'b0;
                        resp_valid_reg    <= 1'b1;
                        resp_readdata_reg <= '0;
                        gap_cnt_reg       <= '0;
                        state_reg         <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
